// File: rtl/tb_timer.sv
// 8-bit up/down timer with prescaler, sticky wrap flags and a zero-wait APB-style
// register port. Flags are raised only by counting ticks, never by loads.
module tb_timer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq_ovf,
  output logic              irq_udf
);

  localparam logic [ADDR_W-1:0] A_TDR    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TCR    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TSR    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TCNT   = ADDR_W'(3);
  localparam logic [DATA_W-1:0] TCR_MASK = DATA_W'(8'hB3);

  logic [DATA_W-1:0] tdr_q, tdr_d;
  logic [DATA_W-1:0] tcr_q, tcr_d;
  logic [1:0]        tsr_q, tsr_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [3:0]        presc_q, presc_d;

  logic       wr_en;
  logic       tick;
  logic [1:0] flag_set;
  logic [1:0] flag_clr;

  wire ld_bit  = tcr_q[7];
  wire dir_bit = tcr_q[5];
  wire en_bit  = tcr_q[4];
  wire [1:0] cks = tcr_q[1:0];

  // Tick fires when the low (cks+1) prescaler bits are all ones.
  always_comb begin
    tick = 1'b0;
    case (cks)
      2'd0:    tick = presc_q[0];
      2'd1:    tick = &presc_q[1:0];
      2'd2:    tick = &presc_q[2:0];
      default: tick = &presc_q;
    endcase
  end

  always_comb begin
    wr_en    = psel & penable & pwrite;
    tdr_d    = tdr_q;
    tcr_d    = tcr_q;
    cnt_d    = cnt_q;
    flag_set = 2'b00;
    flag_clr = 2'b00;
    presc_d  = presc_q + 4'd1;

    if (wr_en && paddr == A_TDR) tdr_d = pwdata;
    if (wr_en && paddr == A_TCR) tcr_d = pwdata & TCR_MASK;
    if (wr_en && paddr == A_TSR) flag_clr = pwdata[1:0];

    if (ld_bit) begin
      cnt_d = tdr_q;
    end else if (en_bit && tick) begin
      if (dir_bit) begin
        cnt_d       = cnt_q - DATA_W'(1);
        flag_set[1] = (cnt_q == '0);
      end else begin
        cnt_d       = cnt_q + DATA_W'(1);
        flag_set[0] = (cnt_q == '1);
      end
    end

    // Set beats clear when both land in the same cycle.
    tsr_d = (tsr_q & ~flag_clr) | flag_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdr_q   <= '0;
      tcr_q   <= '0;
      tsr_q   <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
    end else begin
      tdr_q   <= tdr_d;
      tcr_q   <= tcr_d;
      tsr_q   <= tsr_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (psel) begin
      case (paddr)
        A_TDR:   prdata = tdr_q;
        A_TCR:   prdata = tcr_q;
        A_TSR:   prdata = DATA_W'(tsr_q);
        A_TCNT:  prdata = cnt_q;
        default: prdata = '0;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign irq_ovf = tsr_q[0];
  assign irq_udf = tsr_q[1];

endmodule

// File: tb/tb_tb_timer.sv
// Self-checking bench for tb_timer: directed scenarios followed by random bus
// traffic, all compared against a cycle-level reference model of the register map.
module tb_tb_timer;

  logic       clk;
  logic       rst;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr, irq_ovf, irq_udf;

  int total = 0;
  int bad   = 0;

  tb_timer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq_ovf(irq_ovf), .irq_udf(irq_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents plus the number of clocks since reset.
  logic [7:0] m_tdr, m_tcr, m_tsr, m_cnt;
  int         m_cyc;

  function automatic bit m_tick();
    int period;
    period = 2 ** (int'(m_tcr[1:0]) + 1);
    return (m_cyc % period) == (period - 1);
  endfunction

  function automatic logic [7:0] m_wraps();
    if (m_tcr[7] || !m_tcr[4] || !m_tick()) return 8'h00;
    if (!m_tcr[5] && m_cnt == 8'd255) return 8'h01;
    if (m_tcr[5] && m_cnt == 8'd0) return 8'h02;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_step_cnt();
    if (m_tcr[7]) return m_tdr;
    if (m_tcr[4] && m_tick()) return m_tcr[5] ? 8'((int'(m_cnt) + 255) % 256)
                                              : 8'((int'(m_cnt) + 1) % 256);
    return m_cnt;
  endfunction

  function automatic logic [7:0] m_clear();
    if (psel && penable && pwrite && paddr == 8'h02) return pwdata & 8'h03;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return m_tsr;
      8'h03:   return m_cnt;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdr <= 8'h00;
      m_tcr <= 8'h00;
      m_tsr <= 8'h00;
      m_cnt <= 8'h00;
      m_cyc <= 0;
    end else begin
      if (psel && penable && pwrite && paddr == 8'h00) m_tdr <= pwdata;
      if (psel && penable && pwrite && paddr == 8'h01) m_tcr <= pwdata & 8'hB3;
      m_tsr <= (m_tsr & ~m_clear()) | m_wraps();
      m_cnt <= m_step_cnt();
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("wr addr=%02h data=%02h", a, d);
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    check("rd_model", d, m_read(a));
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    $display("rd addr=%02h data=%02h", a, d);
  endtask

  task automatic check_irqs(input string tag);
    #1;
    check({tag, "_ovf"}, 8'(irq_ovf), 8'(m_tsr[0]));
    check({tag, "_udf"}, 8'(irq_udf), 8'(m_tsr[1]));
  endtask

  task automatic wait_flag(input bit which_udf, input string tag);
    int k;
    for (k = 0; k < 10 && !(which_udf ? irq_udf : irq_ovf); k++) @(negedge clk);
    check(tag, 8'(which_udf ? irq_udf : irq_ovf), 8'h01);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_irq_ovf", 8'(irq_ovf), 8'h00);
    check("rst_irq_udf", 8'(irq_udf), 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check_irqs("rst");
    for (int a = 0; a < 4; a++) begin
      apb_read(8'(a), d);
      check("rst_reg", d, 8'h00);
    end

    // Loads that jump across the wrap point must not raise a flag
    apb_write(8'h00, 8'hFF); apb_write(8'h01, 8'h80);
    apb_write(8'h00, 8'h00); apb_write(8'h01, 8'h80);
    apb_read(8'h02, d); check("fake_ovf_dis", d & 8'h01, 8'h00);
    apb_read(8'h03, d); check("fake_ovf_cnt", d, 8'h00);

    apb_write(8'h00, 8'hFF); apb_write(8'h01, 8'h80);
    apb_write(8'h00, 8'h00); apb_write(8'h01, 8'h90);
    apb_read(8'h02, d); check("fake_ovf_en", d & 8'h01, 8'h00);

    // Genuine overflow, then W1C
    apb_write(8'h00, 8'hFE); apb_write(8'h01, 8'h80); apb_write(8'h01, 8'h10);
    wait_flag(1'b0, "ovf_wait");
    check_irqs("ovf");
    apb_read(8'h02, d); check("ovf_tsr", d, 8'h01);
    apb_write(8'h02, 8'h01);
    apb_read(8'h02, d); check("ovf_clr", d, 8'h00);

    // Genuine underflow
    apb_write(8'h00, 8'h01); apb_write(8'h01, 8'h80); apb_write(8'h01, 8'h30);
    wait_flag(1'b1, "udf_wait");
    apb_read(8'h02, d); check("udf_tsr", d, 8'h02);
    apb_write(8'h02, 8'h00);
    apb_read(8'h02, d); check("w0_noeffect", d, 8'h02);
    apb_write(8'h02, 8'h03);

    // Fake underflow via load with en and down selected
    apb_write(8'h00, 8'h00); apb_write(8'h01, 8'hB0);
    apb_write(8'h00, 8'hFF);
    repeat (3) @(negedge clk);
    apb_read(8'h02, d); check("fake_udf", d & 8'h02, 8'h00);
    apb_read(8'h03, d); check("fake_udf_cnt", d, 8'hFF);

    // Prescaler at the slowest setting
    do_reset();
    apb_write(8'h00, 8'h00); apb_write(8'h01, 8'h80); apb_write(8'h01, 8'h13);
    repeat (16) @(negedge clk);
    apb_read(8'h03, d); check("presc_16", d, m_cnt);
    repeat (16) @(negedge clk);
    apb_read(8'h03, d); check("presc_32", d, m_cnt);
    apb_read(8'h07, d); check("unmapped", d, 8'h00);
    apb_write(8'h07, 8'h5A);
    apb_read(8'h00, d); check("unmapped_wr", d, 8'h00);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int op;
      logic [7:0] a, v;
      op = int'($urandom_range(0, 9));
      if (i == 300) begin
        do_reset();
        apb_read(8'h03, d); check("midreset_cnt", d, 8'h00);
      end else if (op <= 2) begin
        a = 8'($urandom_range(0, 4));
        case ($urandom_range(0, 4))
          0: v = 8'h00;
          1: v = 8'h01;
          2: v = 8'hFE;
          3: v = 8'hFF;
          default: v = 8'($urandom);
        endcase
        if (a == 8'h01 && $urandom_range(0, 3) != 0) v[7] = 1'b0;
        apb_write(a, v);
      end else if (op <= 6) begin
        apb_read(8'($urandom_range(0, 7)), d);
      end else begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        check_irqs("idle");
        check("idle_prdata", prdata, 8'h00);
        check("pready", 8'(pready), 8'h01);
        check("pslverr", 8'(pslverr), 8'h00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
